logo_scroll_ctrl: RTL and testbench
===================================

Name: logo_scroll_ctrl

Overview:
- Per-frame sequencer for the VGA logo letter painters.
- At start-up it reveals the letters one at a time.
- It then bounces the shared horizontal offset `delt` between 0 and MAX_DELT, with a dwell at each end.
- It sits between the VGA timing generator (frame pulse) and the letter painters; `delt` and `letter_en` feed each painter's offset and enable inputs directly.

Parameters:
- MAX_DELT, 200, right-hand bound of `delt` in pixels; MAX_DELT+STEP < 2048.
- STEP, 2, pixels moved per step event; ≥1.
- FRAME_DIV, 1, frames per step event; ≥1.
- PAUSE_FRAMES, 60, frames to dwell at each end; ≥1.
- N_LETTERS, 4, number of letter enables.
- REVEAL_FRAMES, 30, frames between successive letter reveals; ≥1.

Ports:
- clk  input  1  pixel/system clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  high = sequencing runs; low = freeze all state.
- frame_start  input  1  from VGA timing, high at start of vertical blank; may be held for several cycles.
- restart  input  1  synchronous one-cycle request to restart the reveal sequence.
- delt  output  11  horizontal logo offset, registered.
- letter_en  output  N_LETTERS  per-letter enable; bit 0 is the first letter revealed; registered.
- dir  output  1  0 = moving right, 1 = moving left; registered.
- state  output  3  FSM state code: REVEAL=0, SCROLL_R=1, PAUSE_R=2, SCROLL_L=3, PAUSE_L=4.

Behaviour:
- **Reset** (rst low, asynchronous, immediate): delt=0, letter_en=0, dir=0, state=REVEAL, all internal counters=0, frame_start edge register=0.
- **Frame tick:** tick = frame_start & ~frame_start_q, where frame_start_q is frame_start registered. A held-high frame_start gives exactly one tick.
- **All updates** occur at the clk edge that samples tick. Outputs change one cycle after the rising edge of frame_start, i.e. inside vertical blank, so there is no mid-frame tearing.
- **enable low:** ticks are ignored and all registers hold. The edge register still tracks frame_start, so no stale tick fires when enable returns.
- **restart** (when enable is high) has priority over tick. Next cycle: delt=0, letter_en=0, dir=0, counters=0, state=REVEAL. restart is ignored while enable is low.
- **REVEAL:**
  - rev_cnt increments on each tick.
  - When a tick arrives with rev_cnt==REVEAL_FRAMES-1: rev_cnt:=0 and letter_en:={letter_en[N-2:0],1'b1}.
  - If that shift sets the final bit, state:=SCROLL_R and div_cnt:=0 in the same update.
- **Step event:** a tick while in SCROLL_R or SCROLL_L with div_cnt==FRAME_DIV-1; div_cnt then wraps to 0. On other ticks in those states, div_cnt increments.
- **SCROLL_R:**
  - On a step event, delt:=min(delt+STEP, MAX_DELT), computed in 12 bits.
  - If the new value equals MAX_DELT: state:=PAUSE_R, pause_cnt:=0.
- **PAUSE_R:**
  - pause_cnt increments on each tick.
  - On the tick with pause_cnt==PAUSE_FRAMES-1: state:=SCROLL_L, dir:=1, div_cnt:=0.
- **SCROLL_L:**
  - On a step event, delt:=(delt≥STEP)?delt-STEP:0.
  - If the new value is 0: state:=PAUSE_L, pause_cnt:=0.
- **PAUSE_L:** mirror of PAUSE_R. On exit: state:=SCROLL_R, dir:=0, div_cnt:=0.
- **Invariants:** delt never exceeds MAX_DELT and never underflows. letter_en stays all ones in every non-REVEAL state. Unused state codes (5-7) go to REVEAL with restart semantics on the next clk.

Test Plan:
Bench parameters: MAX_DELT=10, STEP=4, FRAME_DIV=2, PAUSE_FRAMES=3, N_LETTERS=3, REVEAL_FRAMES=2.
- **Reset:** hold rst low for 3 clk with frame_start toggling -> delt=0, letter_en=000, dir=0, state=0 throughout. Release, then one cycle with no tick -> outputs unchanged.
- **Reveal:** 6 ticks, each a single-cycle frame_start pulse -> letter_en=001 after tick 2, 011 after tick 4, 111 and state=1 after tick 6. Each change appears one clk after the pulse.
- **Bounce:**
  - After reveal, 6 ticks -> delt=4, 8, 10 (saturated) after ticks 2, 4, 6; state=2.
  - 3 more ticks -> state=3, dir=1.
  - 6 more ticks -> delt=6, 2, 0, then state=4.
  - 3 more ticks -> state=1, dir=0.
- **Held frame / freeze:** frame_start held high for 50 cycles in SCROLL_R -> div_cnt advances by exactly one. enable low across 5 frame_start pulses -> delt/state unchanged. enable high, then 1 pulse -> exactly one tick is counted.
- **Restart priority:** restart asserted in SCROLL_L on the same cycle as a tick, with delt=6 -> next cycle delt=0, letter_en=000, dir=0, state=0. Reveal timing then restarts from rev_cnt=0.
- **Async reset mid-run:** rst driven low between clk edges in PAUSE_R -> outputs clear before the next clk edge. After release, behaviour matches the Reset scenario.

Source files
------------

// File: rtl/logo_scroll_ctrl.sv
// rtl/logo_scroll_ctrl.sv - per-frame reveal/bounce sequencer for the VGA logo letter painters
module logo_scroll_ctrl #(
  parameter int MAX_DELT      = 200,
  parameter int STEP          = 2,
  parameter int FRAME_DIV     = 1,
  parameter int PAUSE_FRAMES  = 60,
  parameter int N_LETTERS     = 4,
  parameter int REVEAL_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_start,
  input  logic                 restart,
  output logic [10:0]          delt,
  output logic [N_LETTERS-1:0] letter_en,
  output logic                 dir,
  output logic [2:0]           state
);

  localparam logic [2:0] S_REVEAL   = 3'd0;
  localparam logic [2:0] S_SCROLL_R = 3'd1;
  localparam logic [2:0] S_PAUSE_R  = 3'd2;
  localparam logic [2:0] S_SCROLL_L = 3'd3;
  localparam logic [2:0] S_PAUSE_L  = 3'd4;

  localparam logic [15:0] REV_LAST   = 16'(REVEAL_FRAMES - 1);
  localparam logic [15:0] DIV_LAST   = 16'(FRAME_DIV - 1);
  localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_FRAMES - 1);
  localparam logic [11:0] MAX12      = 12'(MAX_DELT);
  localparam logic [11:0] STEP12     = 12'(STEP);
  localparam logic [10:0] MAX11      = 11'(MAX_DELT);
  localparam logic [10:0] STEP11     = 11'(STEP);

  logic [2:0]           state_d;
  logic                 frame_start_q;
  logic                 tick;
  logic [10:0]          delt_d;
  logic [N_LETTERS-1:0] letter_d;
  logic                 dir_d;
  logic [15:0]          rev_cnt, rev_d;
  logic [15:0]          div_cnt, div_d;
  logic [15:0]          pause_cnt, pause_d;

  logic [11:0]          sum12;
  logic [10:0]          delt_up;
  logic [10:0]          delt_dn;
  logic [N_LETTERS:0]   shift_wide;
  logic [N_LETTERS-1:0] letter_shift;
  logic                 rev_last;
  logic                 div_last;
  logic                 pause_last;
  logic                 clear;

  // One tick per rising edge of frame_start, however long it is held.
  assign tick         = frame_start & ~frame_start_q;
  assign rev_last     = (rev_cnt == REV_LAST);
  assign div_last     = (div_cnt == DIV_LAST);
  assign pause_last   = (pause_cnt == PAUSE_LAST);
  assign sum12        = {1'b0, delt} + STEP12;
  assign delt_up      = (sum12 >= MAX12) ? MAX11 : sum12[10:0];
  assign delt_dn      = (delt >= STEP11) ? (delt - STEP11) : 11'd0;
  assign shift_wide   = {letter_en, 1'b1};
  assign letter_shift = shift_wide[N_LETTERS-1:0];
  assign clear        = restart | (state > S_PAUSE_L);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_REVEAL;
      frame_start_q <= 1'b0;
      delt          <= 11'd0;
      letter_en     <= '0;
      dir           <= 1'b0;
      rev_cnt       <= 16'd0;
      div_cnt       <= 16'd0;
      pause_cnt     <= 16'd0;
    end else begin
      state         <= state_d;
      frame_start_q <= frame_start;
      delt          <= delt_d;
      letter_en     <= letter_d;
      dir           <= dir_d;
      rev_cnt       <= rev_d;
      div_cnt       <= div_d;
      pause_cnt     <= pause_d;
    end
  end

  always_comb begin
    state_d = state;
    if (enable) begin
      if (clear) begin
        state_d = S_REVEAL;
      end else if (tick) begin
        case (state)
          S_REVEAL:   if (rev_last && letter_shift[N_LETTERS-1]) state_d = S_SCROLL_R;
          S_SCROLL_R: if (div_last && delt_up == MAX11) state_d = S_PAUSE_R;
          S_PAUSE_R:  if (pause_last) state_d = S_SCROLL_L;
          S_SCROLL_L: if (div_last && delt_dn == 11'd0) state_d = S_PAUSE_L;
          S_PAUSE_L:  if (pause_last) state_d = S_SCROLL_R;
          default:    state_d = S_REVEAL;
        endcase
      end
    end
  end

  always_comb begin
    delt_d   = delt;
    letter_d = letter_en;
    dir_d    = dir;
    rev_d    = rev_cnt;
    div_d    = div_cnt;
    pause_d  = pause_cnt;
    if (enable) begin
      if (clear) begin
        delt_d   = 11'd0;
        letter_d = '0;
        dir_d    = 1'b0;
        rev_d    = 16'd0;
        div_d    = 16'd0;
        pause_d  = 16'd0;
      end else if (tick) begin
        case (state)
          S_REVEAL: begin
            rev_d = rev_cnt + 16'd1;
            if (rev_last) begin
              rev_d    = 16'd0;
              letter_d = letter_shift;
              if (letter_shift[N_LETTERS-1]) div_d = 16'd0;
            end
          end
          S_SCROLL_R: begin
            if (div_last) begin
              div_d  = 16'd0;
              delt_d = delt_up;
              if (delt_up == MAX11) pause_d = 16'd0;
            end else begin
              div_d = div_cnt + 16'd1;
            end
          end
          S_PAUSE_R: begin
            pause_d = pause_cnt + 16'd1;
            if (pause_last) begin
              dir_d = 1'b1;
              div_d = 16'd0;
            end
          end
          S_SCROLL_L: begin
            if (div_last) begin
              div_d  = 16'd0;
              delt_d = delt_dn;
              if (delt_dn == 11'd0) pause_d = 16'd0;
            end else begin
              div_d = div_cnt + 16'd1;
            end
          end
          S_PAUSE_L: begin
            pause_d = pause_cnt + 16'd1;
            if (pause_last) begin
              dir_d = 1'b0;
              div_d = 16'd0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// tb/tb_logo_scroll_ctrl.sv - scoreboard bench for logo_scroll_ctrl against a frame-level model
module tb_logo_scroll_ctrl;
  localparam int MAX_DELT = 10, STEP = 4, FRAME_DIV = 2, PAUSE_FRAMES = 3;
  localparam int N_LETTERS = 3, REVEAL_FRAMES = 2;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, frame_start = 1'b0, restart = 1'b0;
  logic [10:0] delt;
  logic [N_LETTERS-1:0] letter_en;
  logic dir;
  logic [2:0] state;

  always #5 clk = ~clk;

  logo_scroll_ctrl #(
    .MAX_DELT(MAX_DELT), .STEP(STEP), .FRAME_DIV(FRAME_DIV),
    .PAUSE_FRAMES(PAUSE_FRAMES), .N_LETTERS(N_LETTERS), .REVEAL_FRAMES(REVEAL_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start), .restart(restart),
    .delt(delt), .letter_en(letter_en), .dir(dir), .state(state)
  );

  typedef struct {
    int delt;
    int le;
    int dir;
    int st;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: phase 0..4, number of letters shown, frames counted in the current phase.
  int m_phase, m_shown, m_rev_frames, m_div_frames, m_pause_frames, m_delt, m_dir;
  bit m_fs_prev;

  function automatic void m_clear();
    m_phase = 0; m_shown = 0; m_rev_frames = 0; m_div_frames = 0;
    m_pause_frames = 0; m_delt = 0; m_dir = 0;
  endfunction

  function automatic void model_step(bit r, bit en, bit fs, bit rs);
    bit tick;
    if (!r) begin
      m_clear();
      m_fs_prev = 1'b0;
      return;
    end
    tick = fs && !m_fs_prev;
    m_fs_prev = fs;
    if (!en) return;
    if (rs) begin
      m_clear();
      return;
    end
    if (!tick) return;
    case (m_phase)
      0: begin
        m_rev_frames++;
        if (m_rev_frames == REVEAL_FRAMES) begin
          m_rev_frames = 0;
          m_shown++;
          if (m_shown == N_LETTERS) begin m_phase = 1; m_div_frames = 0; end
        end
      end
      1, 3: begin
        m_div_frames++;
        if (m_div_frames == FRAME_DIV) begin
          m_div_frames = 0;
          if (m_phase == 1) begin
            m_delt = (m_delt + STEP > MAX_DELT) ? MAX_DELT : m_delt + STEP;
            if (m_delt == MAX_DELT) begin m_phase = 2; m_pause_frames = 0; end
          end else begin
            m_delt = (m_delt - STEP < 0) ? 0 : m_delt - STEP;
            if (m_delt == 0) begin m_phase = 4; m_pause_frames = 0; end
          end
        end
      end
      default: begin
        m_pause_frames++;
        if (m_pause_frames == PAUSE_FRAMES) begin
          m_phase = (m_phase == 2) ? 3 : 1;
          m_dir = (m_phase == 3) ? 1 : 0;
          m_div_frames = 0;
        end
      end
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Inputs change on the falling edge; the expected post-edge outputs are queued.
  task automatic cyc(input bit fs, input bit en, input bit rs, input bit r);
    exp_t e;
    @(negedge clk);
    frame_start = fs; enable = en; restart = rs; rst = r;
    model_step(r, en, fs, rs);
    e.delt = m_delt; e.le = (1 << m_shown) - 1; e.dir = m_dir; e.st = m_phase;
    q.push_back(e);
  endtask

  task automatic pulse();
    cyc(1, 1, 0, 1);
    cyc(0, 1, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("delt", int'(delt), e.delt);
        chk("letter_en", int'(letter_en), e.le);
        chk("dir", int'(dir), e.dir);
        chk("state", int'(state), e.st);
      end
    end
  end

  initial begin : stim
    int n;
    m_clear();
    m_fs_prev = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset_delt", int'(delt), 0);
    chk("reset_state", int'(state), 0);

    cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);

    for (int i = 0; i < 6; i++) pulse();
    @(posedge clk); #2;
    chk("reveal_letters", int'(letter_en), 7);
    chk("reveal_state", int'(state), 1);

    for (int i = 0; i < 6; i++) pulse();
    @(posedge clk); #2;
    chk("bounce_sat", int'(delt), MAX_DELT);
    chk("bounce_pause_r", int'(state), 2);
    for (int i = 0; i < 3; i++) pulse();
    for (int i = 0; i < 6; i++) pulse();
    @(posedge clk); #2;
    chk("bounce_left_zero", int'(delt), 0);
    chk("bounce_pause_l", int'(state), 4);
    for (int i = 0; i < 3; i++) pulse();
    @(posedge clk); #2;
    chk("bounce_back_right", int'(state), 1);
    chk("bounce_dir", int'(dir), 0);

    for (int i = 0; i < 50; i++) cyc(1, 1, 0, 1);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
    end
    cyc(0, 1, 0, 1);
    pulse();

    n = 0;
    while (!(m_phase == 3 && m_delt == 6) && n < 100) begin pulse(); n++; end
    chk("reach_scroll_l_6", n < 100 ? 1 : 0, 1);
    cyc(1, 1, 1, 1);
    @(posedge clk); #2;
    chk("restart_delt", int'(delt), 0);
    chk("restart_state", int'(state), 0);
    chk("restart_letters", int'(letter_en), 0);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 7; i++) pulse();

    n = 0;
    while (m_phase != 2 && n < 100) begin pulse(); n++; end
    chk("reach_pause_r", n < 100 ? 1 : 0, 1);
    cyc(0, 1, 0, 0);
    #1;
    chk("async_delt", int'(delt), 0);
    chk("async_state", int'(state), 0);
    chk("async_letters", int'(letter_en), 0);
    cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 299) == 0, $urandom_range(0, 599) != 0);
    end

    n = 0;
    while (q.size() > 0 && n < 10) begin @(posedge clk); n++; end
    @(posedge clk); #2;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
